// File: rtl/cmp_pkg.sv
// Shared encodings for the serial magnitude comparator: FSM states, running
// verdict codes and the verdict-to-flags mapping.
package cmp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPARE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CMP_EQ = 2'd0,
    CMP_GT = 2'd1,
    CMP_LT = 2'd2
  } verdict_t;

  // Returns {gt, eq, lt}; an unused verdict code maps to all-zero flags.
  function automatic logic [2:0] verdict_to_flags(input verdict_t v);
    logic [2:0] f;
    case (v)
      CMP_GT:  f = 3'b100;
      CMP_EQ:  f = 3'b010;
      CMP_LT:  f = 3'b001;
      default: f = 3'b000;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/digit_cmp2.sv
// Combinational unsigned compare of one 2-bit digit pair.
module digit_cmp2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic       gt,
  output logic       eq,
  output logic       lt
);

  assign gt = (a > b);
  assign eq = (a == b);
  assign lt = (a < b);

endmodule

// File: rtl/serial_mag_comparator.sv
// Digit-serial magnitude comparator, MSB digit first, with valid/ready on both sides.
// Define CMP_SIGNED_EN to treat operands as two's complement (sign in bit 1 of the first digit).
module serial_mag_comparator
  import cmp_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] a_digit,
  input  logic [1:0] b_digit,
  input  logic       digit_valid,
  output logic       digit_ready,
  output logic       res_valid,
  input  logic       res_ready,
  output logic       A_gt_b,
  output logic       A_eq_b,
  output logic       A_lt_b,
  output logic       busy
);

  localparam int CNT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(NUM_DIGITS - 1);

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  verdict_t         verdict_r, verdict_s;
  logic [2:0]       flags_r, flags_s;
  logic             dgt_s, deq_s, dlt_s;
  verdict_t         digit_uns_s, digit_verdict_s;

  digit_cmp2 u_digit_cmp2 (
    .a  (a_digit),
    .b  (b_digit),
    .gt (dgt_s),
    .eq (deq_s),
    .lt (dlt_s)
  );

  // Encode the digit comparator outputs as a verdict code.
  always_comb begin
    digit_uns_s = CMP_EQ;
    case ({dgt_s, deq_s, dlt_s})
      3'b100:  digit_uns_s = CMP_GT;
      3'b001:  digit_uns_s = CMP_LT;
      default: digit_uns_s = CMP_EQ;
    endcase
  end

`ifdef CMP_SIGNED_EN
  // On the MSB digit, differing sign bits decide the verdict outright.
  always_comb begin
    digit_verdict_s = digit_uns_s;
    if ((cnt_r == {CNT_W{1'b0}}) && (a_digit[1] != b_digit[1])) begin
      digit_verdict_s = a_digit[1] ? CMP_LT : CMP_GT;
    end else begin
      digit_verdict_s = digit_uns_s;
    end
  end
`else
  // Unsigned build: every digit uses the plain digit verdict.
  always_comb begin
    digit_verdict_s = digit_uns_s;
  end
`endif

  // Next-state, counter, verdict and flag logic.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    verdict_s = verdict_r;
    flags_s   = flags_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s   = ST_COMPARE;
          cnt_s     = {CNT_W{1'b0}};
          verdict_s = CMP_EQ;
          flags_s   = 3'b000;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_COMPARE: begin
        if (digit_valid) begin
          // First unequal digit decides; later digits cannot overturn it.
          if (verdict_r == CMP_EQ) begin
            verdict_s = digit_verdict_s;
          end else begin
            verdict_s = verdict_r;
          end
          if (cnt_r == LAST_DIGIT) begin
            state_s = ST_DONE;
            flags_s = verdict_to_flags(verdict_s);
          end else begin
            cnt_s = cnt_r + CNT_W'(1'b1);
          end
        end else begin
          state_s = ST_COMPARE;
        end
      end
      ST_DONE: begin
        if (res_ready) begin
          state_s = ST_IDLE;
          flags_s = 3'b000;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s   = ST_IDLE;
        cnt_s     = {CNT_W{1'b0}};
        verdict_s = CMP_EQ;
        flags_s   = 3'b000;
      end
    endcase
  end

  // State, counter, verdict and flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      verdict_r <= CMP_EQ;
      flags_r   <= 3'b000;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      verdict_r <= verdict_s;
      flags_r   <= flags_s;
    end
  end

  assign digit_ready = (state_r == ST_COMPARE);
  assign res_valid   = (state_r == ST_DONE);
  assign busy        = (state_r != ST_IDLE);
  assign A_gt_b      = flags_r[2];
  assign A_eq_b      = flags_r[1];
  assign A_lt_b      = flags_r[0];

endmodule
